// File: rtl/softer_max_pkg.sv
// Shared constants, stage-1 lane record and pow2 fraction table builder
// for the Softer_max datapath.
package softer_max_pkg;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int OUT_W  = 16;
  localparam int LANES  = 4;

  localparam int INT_W  = DATA_W - FRAC_W;
  localparam int E_W    = INT_W + 1;
  localparam int LUT_W  = FRAC_W + 1;
  // Widest left-shift product: lut value shifted by the largest positive e.
  localparam int WIDE_W = LUT_W + (1 << INT_W) - 1;

  typedef struct packed {
    logic [LUT_W-1:0]      lut;
    logic signed [E_W-1:0] e;
  } s1_lane_t;

  // round_half_up(2^(f/2^frac_w) * 2^frac_w), evaluated at elaboration.
  function automatic int pow2_frac_entry(input int f, input int frac_w);
    real scale;
    real r;
    scale = 2.0 ** frac_w;
    r     = scale * (2.0 ** (real'(f) / scale));
    return int'($floor(r + 0.5));
  endfunction
endpackage

// File: rtl/pow2_frac_lut.sv
// Combinational fractional-part table: frac_i -> 2^(frac/2^FRAC_W) in
// unsigned fixed point with FRAC_W fractional bits.
module pow2_frac_lut
  import softer_max_pkg::*;
(
  input  logic [FRAC_W-1:0] frac_i,
  output logic [LUT_W-1:0]  lut_o
);
  logic [LUT_W-1:0] table_s [2**FRAC_W];

  for (genvar g = 0; g < 2**FRAC_W; g++) begin : g_tab
    assign table_s[g] = LUT_W'(pow2_frac_entry(g, FRAC_W));
  end

  assign lut_o = table_s[frac_i];
endmodule

// File: rtl/pow2_vec_pipe.sv
// Two-stage, LANES-wide 2^(x - max) unit with valid/ready backpressure.
// Define POW2_SAT_EN to saturate left-shift overflow instead of wrapping.
module pow2_vec_pipe
  import softer_max_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_x,
  input  logic [INT_W-1:0]         in_max,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_y,
  output logic                     out_last
);
  s1_lane_t [LANES-1:0]   s1_d, s1_q;
  logic                   v1_d, v1_q, last1_d, last1_q;
  logic                   v2_d, v2_q, last2_d, last2_q;
  logic [LANES*OUT_W-1:0] y_d, y_q;
  logic                   s1_load_s, s2_load_s;
  logic [LUT_W-1:0]       lut_s [LANES];

  assign s2_load_s = !v2_q || out_ready;
  assign s1_load_s = !v1_q || s2_load_s;
  assign in_ready  = !v1_q || !v2_q || out_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pow2_frac_lut u_lut (
      .frac_i (in_x[l*DATA_W +: FRAC_W]),
      .lut_o  (lut_s[l])
    );
  end

  function automatic logic [OUT_W-1:0] shift_lane(input s1_lane_t r);
    logic [WIDE_W-1:0] wide;
    logic [E_W-1:0]    mag;
    logic [OUT_W-1:0]  y;
    wide = '0;
    mag  = '0;
    y    = '0;
    if (!r.e[E_W-1]) begin
      mag  = r.e;
      wide = WIDE_W'(r.lut) << mag;
`ifdef POW2_SAT_EN
      if (|wide[WIDE_W-1:OUT_W]) begin
        y = '1;
      end else begin
        y = wide[OUT_W-1:0];
      end
`else
      y = wide[OUT_W-1:0];
`endif
    end else begin
      mag = E_W'(-r.e);
      if (int'(mag) >= OUT_W) begin
        y = '0;
      end else begin
        y = OUT_W'(r.lut) >> mag;
      end
    end
    return y;
  endfunction

  // Stage 1 next state: table lookup and exponent per lane.
  always_comb begin
    s1_d    = s1_q;
    v1_d    = v1_q;
    last1_d = last1_q;
    if (s1_load_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        last1_d = in_last;
        for (int l = 0; l < LANES; l++) begin
          s1_d[l].lut = lut_s[l];
          s1_d[l].e   = E_W'($signed(in_x[l*DATA_W+FRAC_W +: INT_W]))
                      - E_W'($signed(in_max));
        end
      end else begin
        last1_d = last1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 next state: shift and width reduction per lane.
  always_comb begin
    y_d     = y_q;
    v2_d    = v2_q;
    last2_d = last2_q;
    if (s2_load_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        last2_d = last1_q;
        for (int l = 0; l < LANES; l++) begin
          y_d[l*OUT_W +: OUT_W] = shift_lane(s1_q[l]);
        end
      end else begin
        last2_d = last2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers; reset discards any in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      y_q     <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      v1_q    <= v1_d;
      last1_q <= last1_d;
      y_q     <= y_d;
      v2_q    <= v2_d;
      last2_q <= last2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_y     = y_q;
  assign out_last  = last2_q;
endmodule

// File: tb/tb_pow2_vec_pipe.sv
// Directed bench for pow2_vec_pipe with an arithmetic reference model and
// an every-cycle handshake/ordering/stability checker.
module tb_pow2_vec_pipe;
  import softer_max_pkg::*;

  localparam int XW = LANES*DATA_W;
  localparam int YW = LANES*OUT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_x = '0;
  logic [INT_W-1:0] in_max = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [YW-1:0] out_y;
  logic          out_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pow2_vec_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_max    (in_max),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_last  (out_last)
  );

  typedef struct {
    logic [YW-1:0] y;
    logic          last;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: real-valued 2^(f/2^FRAC_W), then integer scaling by 2^e.
  function automatic logic [OUT_W-1:0] model_lane(input logic [DATA_W-1:0] x, input logic [INT_W-1:0] m);
    int     i, f, e;
    longint lut, v;
    real    scale;
    i = $signed(x[DATA_W-1:FRAC_W]);
    f = int'(x[FRAC_W-1:0]);
    e = i - int'($signed(m));
    scale = 2.0 ** FRAC_W;
    lut = longint'($floor(scale * (2.0 ** (real'(f) / scale)) + 0.5));
    if (e >= 0) begin
      v = lut * (longint'(1) << e);
`ifdef POW2_SAT_EN
      if (v >= (longint'(1) << OUT_W)) v = (longint'(1) << OUT_W) - 1;
`else
      v = v % (longint'(1) << OUT_W);
`endif
    end else if (-e >= OUT_W) begin
      v = 0;
    end else begin
      v = lut >> (-e);
    end
    return OUT_W'(v);
  endfunction

  function automatic logic [YW-1:0] model_beat(input logic [XW-1:0] x, input logic [INT_W-1:0] m);
    logic [YW-1:0] y;
    y = '0;
    for (int l = 0; l < LANES; l++) y[l*OUT_W +: OUT_W] = model_lane(x[l*DATA_W +: DATA_W], m);
    return y;
  endfunction

  logic          hold_q = 1'b0;
  logic [YW-1:0] hold_y;
  logic          hold_last;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_q = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (q.size() < 2) || out_ready);
      if (hold_q) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_y", out_y, hold_y);
        check("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("model_y", out_y, e.y);
          check("model_last", out_last, e.last);
        end
      end
      hold_q    = out_valid && !out_ready;
      hold_y    = out_y;
      hold_last = out_last;
      if (in_valid && in_ready) begin
        e.y    = model_beat(in_x, in_max);
        e.last = in_last;
        q.push_back(e);
      end
    end
  end

  task automatic beat_check(input string name, input logic [XW-1:0] x, input logic [INT_W-1:0] m,
                            input logic last, input logic [YW-1:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = x; in_max = m; in_last = last; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_y"}, out_y, exp);
    check({name, "_last"}, out_last, last);
  endtask

  logic [XW-1:0]    bp_x [6] = '{32'h01234567, 32'h89ABCDEF, 32'h10F0E7C3,
                                 32'h7F7E8081, 32'h22334455, 32'h5A6B7C0D};
  logic [INT_W-1:0] bp_m [6] = '{4'h0, 4'h1, 4'hF, 4'h3, 4'hD, 4'h2};

  initial begin
    int k;
    logic saw_low;

    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_y", out_y, 64'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    check("post_rel_in_ready", in_ready, 1'b1);

    beat_check("zero", 32'h00000000, 4'h0, 1'b1, 64'h0010_0010_0010_0010);
    beat_check("x18_m1", 32'h18181818, 4'h1, 1'b0, 64'h0017_0017_0017_0017);
    beat_check("x18_m3", 32'h18181818, 4'h3, 1'b1, 64'h0005_0005_0005_0005);
    beat_check("neg_far", 32'h70108080, 4'h7, 1'b0, 64'h0010_0000_0000_0000);
    beat_check("mixed_m0", 32'hF818000F, 4'h0, 1'b1, 64'h000B_002E_0010_001F);
`ifdef POW2_SAT_EN
    beat_check("left_big", 32'h4880007F, 4'h8, 1'b0, 64'hFFFF_0010_1000_FFFF);
`else
    beat_check("left_big", 32'h4880007F, 4'h8, 1'b0, 64'h7000_0010_1000_8000);
`endif

    // Six back-to-back beats with out_ready dropped for cycles 3..5.
    k = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40 && (k < 6 || q.size() > 0); c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 3 && c <= 5);
      if (k < 6) begin
        in_valid = 1'b1; in_x = bp_x[k]; in_max = bp_m[k]; in_last = (k == 5);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!in_ready) saw_low = 1'b1;
      if (in_valid && in_ready) k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_accepted", k, 6);
    check("bp_in_ready_fell", saw_low, 1'b1);
    check("bp_drained", q.size(), 0);

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_x = 32'h01020304; in_max = 4'h0; in_last = 1'b0;
    @(posedge clk); #1;
    in_x = 32'h11223344;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_y", out_y, 64'h0);
    check("arst_out_last", out_last, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("arst_rel_valid", out_valid, 1'b0);
    beat_check("post_rst", 32'h10101010, 4'h1, 1'b0, 64'h0010_0010_0010_0010);

    repeat (3) @(posedge clk);
    #1 check("final_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
